// File: rtl/cnn_grid_engine.sv
// Time-multiplexed cellular neural network engine: one cell update per cycle over a ROWS x COLS
// grid, with Jacobi sweeps of forward-Euler steps and run-time-loadable A/B templates, bias and U.
module cnn_grid_engine #(
  parameter int WIDTH      = 9,
  parameter int FRAC       = 4,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int ITER_W     = 8,
  parameter int STEP_SHIFT = 2,
  localparam int N         = ROWS * COLS,
  localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [4:0]              cfg_addr,
  input  logic [WIDTH-1:0]        cfg_data,
  input  logic                    u_we,
  input  logic [IW-1:0]           u_addr,
  input  logic [WIDTH-1:0]        u_data,
  input  logic [WIDTH+3:0]        x_init,
  input  logic [ITER_W-1:0]       n_iter,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [N*WIDTH-1:0]      y_out
);

  localparam int XW = WIDTH + 4;
  localparam int AW = 2 * WIDTH + 6;

  localparam logic signed [AW-1:0] XMaxW = AW'((2 ** (XW - 1)) - 1);
  localparam logic signed [AW-1:0] XMinW = AW'(-(2 ** (XW - 1)));
  localparam logic signed [XW-1:0] YMax  = XW'(2 ** FRAC);
  localparam logic signed [XW-1:0] YMin  = XW'(-(2 ** FRAC));

  typedef enum logic [2:0] {StIdle, StInit, StSweep, StCommit, StDone} state_e;

  state_e                   state_q;
  logic [ITER_W-1:0]        iter_q;
  logic [IW-1:0]            idx_q;
  logic signed [XW-1:0]     xi_q;
  logic signed [WIDTH-1:0]  a_q [9];
  logic signed [WIDTH-1:0]  b_q [9];
  logic signed [WIDTH-1:0]  i_q;
  logic signed [WIDTH-1:0]  u_q [N];
  logic signed [XW-1:0]     x_cur_q [N];
  logic signed [XW-1:0]     x_nxt_q [N];

  logic signed [WIDTH-1:0]  y_cell [N];
  logic signed [AW-1:0]     acc;
  logic signed [AW-1:0]     delta;
  logic signed [AW-1:0]     sum;
  logic signed [XW-1:0]     x_new;

  function automatic logic signed [WIDTH-1:0] clamp_y(input logic signed [XW-1:0] x);
    logic signed [XW-1:0] c;
    if (x > YMax)      c = YMax;
    else if (x < YMin) c = YMin;
    else               c = x;
    return c[WIDTH-1:0];
  endfunction

  always_comb begin
    y_out = '0;
    for (int k = 0; k < N; k++) begin
      y_cell[k]                  = clamp_y(x_cur_q[k]);
      y_out[k*WIDTH +: WIDTH]    = y_cell[k];
    end
  end

  // Neighbourhood sum for the cell selected by idx_q; off-grid neighbours are zero-padded.
  always_comb begin
    int cr, cc, nr, nc;
    logic [IW-1:0] nidx;
    logic [3:0]    kk;
    acc  = '0;
    nidx = '0;
    kk   = '0;
    cr   = int'(idx_q) / COLS;
    cc   = int'(idx_q) % COLS;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nr = cr + dr;
        nc = cc + dc;
        if (nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
          nidx = IW'(nr * COLS + nc);
          kk   = 4'((dr + 1) * 3 + dc + 1);
          acc  = acc + AW'(a_q[kk]) * AW'(y_cell[nidx]) + AW'(b_q[kk]) * AW'(u_q[nidx]);
        end
      end
    end
    acc   = acc + (AW'(i_q) <<< FRAC) - (AW'(x_cur_q[idx_q]) <<< FRAC);
    delta = acc >>> (FRAC + STEP_SHIFT);
    sum   = AW'(x_cur_q[idx_q]) + delta;
    if (sum > XMaxW)      x_new = XMaxW[XW-1:0];
    else if (sum < XMinW) x_new = XMinW[XW-1:0];
    else                  x_new = sum[XW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy    <= 1'b0;
      done    <= 1'b0;
      iter_q  <= '0;
      idx_q   <= '0;
      xi_q    <= '0;
      i_q     <= '0;
      for (int k = 0; k < 9; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 0; k < N; k++) begin
        u_q[k]     <= '0;
        x_cur_q[k] <= '0;
        x_nxt_q[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_we) begin
            for (int k = 0; k < 9; k++) begin
              if (cfg_addr == 5'(k))     a_q[k] <= cfg_data;
              if (cfg_addr == 5'(k + 9)) b_q[k] <= cfg_data;
            end
            if (cfg_addr == 5'd18) i_q <= cfg_data;
          end
          if (u_we) begin
            for (int k = 0; k < N; k++) begin
              if (u_addr == IW'(k)) u_q[k] <= u_data;
            end
          end
          if (start) begin
            iter_q  <= n_iter;
            xi_q    <= x_init;
            busy    <= 1'b1;
            state_q <= StInit;
          end
        end
        StInit: begin
          for (int k = 0; k < N; k++) x_cur_q[k] <= xi_q;
          idx_q   <= '0;
          state_q <= (iter_q == '0) ? StDone : StSweep;
        end
        StSweep: begin
          x_nxt_q[idx_q] <= x_new;
          if (idx_q == IW'(N - 1)) begin
            state_q <= StCommit;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        StCommit: begin
          for (int k = 0; k < N; k++) x_cur_q[k] <= x_nxt_q[k];
          iter_q  <= iter_q - ITER_W'(1);
          idx_q   <= '0;
          state_q <= (iter_q == ITER_W'(1)) ? StDone : StSweep;
        end
        StDone: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_grid_engine.sv
// Bench for cnn_grid_engine: directed and randomized runs checked against a grid-level
// reference model of the CNN Euler iteration.
module tb_cnn_grid_engine;

  localparam int WIDTH = 9;
  localparam int FRAC  = 4;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int N     = ROWS * COLS;
  localparam int ONE   = 2 ** FRAC;
  localparam int STEP  = 2 ** (FRAC + 2);
  localparam int XMAX  = 4095;
  localparam int XMIN  = -4096;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_we;
  logic [4:0]         cfg_addr;
  logic [WIDTH-1:0]   cfg_data;
  logic               u_we;
  logic [3:0]         u_addr;
  logic [WIDTH-1:0]   u_data;
  logic [WIDTH+3:0]   x_init;
  logic [7:0]         n_iter;
  logic               start;
  logic               busy;
  logic               done;
  logic [N*WIDTH-1:0] y_out;

  int n_tests = 0;
  int n_fail  = 0;

  int ta [9];
  int tb [9];
  int ti;
  int tu [N];
  int exp_y [N];

  cnn_grid_engine dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .u_we     (u_we),
    .u_addr   (u_addr),
    .u_data   (u_data),
    .x_init   (x_init),
    .n_iter   (n_iter),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .y_out    (y_out)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Jacobi iteration on a plain 2-D integer grid.
  function automatic void model_run(input int xi, input int n);
    int x [N];
    int xn [N];
    int acc;
    for (int k = 0; k < N; k++) x[k] = xi;
    for (int it = 0; it < n; it++) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          acc = 0;
          for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
              if (r + dr >= 0 && r + dr < ROWS && c + dc >= 0 && c + dc < COLS) begin
                acc += ta[(dr+1)*3 + dc + 1] * clampi(x[(r+dr)*COLS + c + dc], -ONE, ONE)
                     + tb[(dr+1)*3 + dc + 1] * tu[(r+dr)*COLS + c + dc];
              end
            end
          end
          acc += ti * ONE - x[r*COLS + c] * ONE;
          xn[r*COLS + c] = clampi(x[r*COLS + c] + floor_div(acc, STEP), XMIN, XMAX);
        end
      end
      x = xn;
    end
    for (int k = 0; k < N; k++) exp_y[k] = clampi(x[k], -ONE, ONE);
  endfunction

  function automatic int y_at(input int k);
    logic signed [WIDTH-1:0] v;
    v = y_out[k*WIDTH +: WIDTH];
    return int'(v);
  endfunction

  task automatic cfg_write(input int addr, input int data);
    logic signed [WIDTH-1:0] d;
    d        = WIDTH'(data);
    cfg_we   = 1'b1;
    cfg_addr = 5'(addr);
    cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (addr < 9)        ta[addr] = int'(d);
    else if (addr < 18)  tb[addr-9] = int'(d);
    else if (addr == 18) ti = int'(d);
  endtask

  task automatic u_write(input int idx, input int data);
    logic signed [WIDTH-1:0] d;
    d      = WIDTH'(data);
    u_we   = 1'b1;
    u_addr = 4'(idx);
    u_data = d;
    @(negedge clk);
    u_we    = 1'b0;
    tu[idx] = int'(d);
  endtask

  // mode: 0 plain, 1 extra start during sweep, 2 cfg write while busy, 3 cfg write with start
  task automatic do_run(input int xi, input int n, input int mode);
    int cyc, got, lim;
    logic signed [WIDTH-1:0] wd;
    x_init = 13'(xi);
    n_iter = 8'(n);
    start  = 1'b1;
    if (mode == 3) begin
      wd       = WIDTH'($urandom);
      cfg_we   = 1'b1;
      cfg_addr = 5'd18;
      cfg_data = wd;
      ti       = int'(wd);
    end
    @(negedge clk);
    start  = 1'b0;
    cfg_we = 1'b0;
    check("busy_after_start", int'(busy), 1);
    model_run(xi, n);
    cyc = 0;
    got = -1;
    lim = 2 + n * (N + 1) + 10;
    while (got < 0 && cyc < lim) begin
      start = (mode == 1 && cyc == 4);
      if (mode == 2 && cyc == 3) begin
        cfg_we   = 1'b1;
        cfg_addr = 5'd18;
        cfg_data = WIDTH'($urandom);
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (done) got = cyc;
    end
    start  = 1'b0;
    cfg_we = 1'b0;
    check("latency", got, 2 + n * (N + 1));
    check("busy_at_done", int'(busy), 0);
    @(negedge clk);
    check("done_single_pulse", int'(done), 0);
    @(negedge clk);
    check("no_requeued_run", int'(busy), 0);
    for (int k = 0; k < N; k++) check($sformatf("y[%0d]", k), y_at(k), exp_y[k]);
  endtask

  initial begin
    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    u_we     = 1'b0;
    u_addr   = '0;
    u_data   = '0;
    x_init   = '0;
    n_iter   = '0;
    start    = 1'b0;
    for (int k = 0; k < 9; k++) begin ta[k] = 0; tb[k] = 0; end
    for (int k = 0; k < N; k++) tu[k] = 0;
    ti = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_y_zero", int'(|y_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Bias only: trajectory 4, 7, 9.
    cfg_write(18, 16);
    do_run(0, 3, 0);
    check("bias_y0_const", y_at(0), 9);

    // Negative bias rounds toward -inf.
    cfg_write(18, -16);
    do_run(0, 1, 0);
    check("neg_round_const", y_at(7), -4);

    // Single-cell input through the centre B tap.
    cfg_write(18, 0);
    cfg_write(13, 32);
    u_write(5, 16);
    do_run(0, 1, 0);
    check("single_cell_const", y_at(5), 8);
    check("single_cell_other", y_at(6), 0);

    // Zero padding at edges and corners.
    cfg_write(13, 0);
    u_write(5, 0);
    for (int k = 0; k < 9; k++) cfg_write(k, 4);
    do_run(8, 1, 0);
    check("pad_corner", y_at(0), 8);
    check("pad_edge", y_at(1), 9);
    check("pad_interior", y_at(5), 10);

    // Saturation, ignored second start, then n_iter = 0.
    for (int k = 0; k < 9; k++) cfg_write(k, (k == 4) ? 32 : 0);
    cfg_write(20, 99);
    do_run(16, 1, 1);
    do_run(16, 0, 0);
    check("n0_sat_const", y_at(3), 16);

    // Randomized templates, inputs and run modes.
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 18; k++) cfg_write(k, int'($urandom_range(0, 511)));
      cfg_write(18, int'($urandom_range(0, 511)));
      for (int k = 0; k < N; k++) u_write(k, int'($urandom_range(0, 511)));
      do_run(int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a sweep clears everything.
    x_init = 13'(100);
    n_iter = 8'd2;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_y_zero", int'(|y_out), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin ta[k] = 0; tb[k] = 0; end
    for (int k = 0; k < N; k++) tu[k] = 0;
    ti = 0;
    @(negedge clk);
    do_run(0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
